// File: rtl/ui_pkg.sv
// Shared types and widths for the peripheral-to-USB transmit path.
package ui_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] last,
  output logic [IdW-1:0] pick,
  output logic           any
);

  int unsigned idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // last < N, so one subtraction is enough to wrap back into range
      idx = 32'(last) + 32'd1 + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!any && req[idx[IdW-1:0]]) begin
        any  = 1'b1;
        pick = idx[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/periph_tx_arbiter.sv
// Round-robin arbiter sharing the FT601 write path among peripheral TX FIFOs, one burst per grant.
module periph_tx_arbiter
  import ui_pkg::*;
#(
  parameter int unsigned NUM_PERIPH = 4,
  parameter int unsigned MAX_BURST  = 16,
  localparam int unsigned ID_W      = $clog2(NUM_PERIPH)
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic [NUM_PERIPH-1:0]        periph_en,
  input  logic [NUM_PERIPH-1:0]        periph_empty,
  input  logic [NUM_PERIPH*DATA_W-1:0] periph_data,
  input  logic [NUM_PERIPH*BE_W-1:0]   periph_valid,
  output logic [NUM_PERIPH-1:0]        periph_rd_en,
  output logic [DATA_W-1:0]            data_o,
  output logic [BE_W-1:0]              valid_o,
  output logic [ID_W-1:0]              src_id,
  output logic                         data_available,
  input  logic                         read_data,
  output logic                         busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  arb_state_t            state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
  logic [NUM_PERIPH-1:0] req;
  logic [ID_W-1:0]       pick;
  logic                  pick_any;
  logic                  avail;
  logic                  xfer;

  assign req = ~periph_empty & periph_en;

  rr_pick #(
    .N (NUM_PERIPH)
  ) u_rr_pick (
    .req  (req),
    .last (last_grant_q),
    .pick (pick),
    .any  (pick_any)
  );

  assign avail = (state_q == ARB_BURST) & ~periph_empty[grant_q] & periph_en[grant_q];
  assign xfer  = avail & read_data;

  assign data_available = avail;
  assign busy           = (state_q == ARB_BURST);

  // Outputs depend on state_q, so an async reset drops rd_en without waiting for a clock.
  always_comb begin
    periph_rd_en = '0;
    data_o       = '0;
    valid_o      = '0;
    src_id       = '0;
    if (state_q == ARB_BURST) begin
      data_o                = periph_data[DATA_W*grant_q +: DATA_W];
      valid_o               = periph_valid[BE_W*grant_q +: BE_W];
      src_id                = grant_q;
      periph_rd_en[grant_q] = xfer;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        // A drained or disabled source releases the grant without popping this cycle
        if (!avail || (xfer && (burst_cnt_q == CntW'(MAX_BURST - 1)))) begin
          state_d      = ARB_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_PERIPH - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_l) begin
      assert ($onehot0(periph_rd_en));
      assert ((periph_rd_en == '0) || ((state_q == ARB_BURST) && read_data));
    end
  end

endmodule
